// File: rtl/proc_controller.sv
// proc_controller: multi-cycle instruction sequencer for the 10-bit processor.
// Drives the 8x10 register file addresses/enables, the ALU command, the A/G
// latch strobes and the register-file input mux select.
//
// Build option: CTRL_COPY_BYPASS_EN
//   defined   - COPY completes in RD, writing Q1 straight back (DSel=10).
//   undefined - COPY takes the RD/EX/WB path through the ALU as PASSB.
//
// state  | meaning
// IDLE   | waiting for EXEC with an instruction word
// LDWAIT | LOAD accepted, waiting for EXEC with the data word
// LDWR   | write latched LOAD data into Rx, DONE
// RD     | read Rx/Ry, load A latch from Q0
// EX     | ALU operation on A and Q1, load G latch
// WB     | write G into Rx, DONE
// ILL    | illegal opcode, DONE with ERR
module proc_controller (
  input  logic       CLKb,
  input  logic       CLR,
  input  logic [9:0] INSTR,
  input  logic       EXEC,
  output logic       BUSY,
  output logic       DONE,
  output logic       ERR,
  output logic [2:0] WRA,
  output logic [2:0] RDA0,
  output logic [2:0] RDA1,
  output logic       ENW,
  output logic       ENR0,
  output logic       Ain,
  output logic       Gin,
  output logic [2:0] ALUcmd,
  output logic [1:0] DSel,
  output logic [9:0] EXTD
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LDWAIT = 3'd1,
    S_LDWR   = 3'd2,
    S_RD     = 3'd3,
    S_EX     = 3'd4,
    S_WB     = 3'd5,
    S_ILL    = 3'd6
  } state_t;

  localparam logic [3:0] OP_LOAD = 4'b0000;
  localparam logic [3:0] OP_COPY = 4'b0001;

  localparam logic [1:0] DSEL_EXTD = 2'b00;
  localparam logic [1:0] DSEL_G    = 2'b01;
`ifdef CTRL_COPY_BYPASS_EN
  localparam logic [1:0] DSEL_Q1   = 2'b10;
`endif

  state_t     state_q, state_d;
  logic [9:0] ir_q, ir_d;
  logic [9:0] extd_q, extd_d;

  logic [3:0] op;
  logic [2:0] rx;
  logic [2:0] ry;
  logic [2:0] alu_sel;

  assign op = ir_q[9:6];
  assign rx = ir_q[5:3];
  assign ry = ir_q[2:0];

  // Opcode to ALU command; COPY passes the B operand through unchanged.
  always_comb begin
    alu_sel = 3'b000;
    case (op)
      4'b0001: alu_sel = 3'b110;
      4'b0010: alu_sel = 3'b000;
      4'b0011: alu_sel = 3'b001;
      4'b0100: alu_sel = 3'b010;
      4'b0101: alu_sel = 3'b011;
      4'b0110: alu_sel = 3'b100;
      4'b0111: alu_sel = 3'b101;
      default: alu_sel = 3'b000;
    endcase
  end

  // State, instruction register and LOAD data register.
  always_ff @(posedge CLKb) begin
    if (CLR) begin
      state_q <= S_IDLE;
      ir_q    <= '0;
      extd_q  <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      extd_q  <= extd_d;
    end
  end

  // Next-state: EXEC only matters in IDLE and LDWAIT, everything else advances unconditionally.
  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    extd_d  = extd_q;
    case (state_q)
      S_IDLE: begin
        if (EXEC) begin
          ir_d = INSTR;
          if (INSTR[9])
            state_d = S_ILL;
          else if (INSTR[9:6] == OP_LOAD)
            state_d = S_LDWAIT;
          else
            state_d = S_RD;
        end
      end
      S_LDWAIT: begin
        if (EXEC) begin
          extd_d  = INSTR;
          state_d = S_LDWR;
        end
      end
      S_LDWR: state_d = S_IDLE;
      S_RD: begin
`ifdef CTRL_COPY_BYPASS_EN
        if (op == OP_COPY)
          state_d = S_IDLE;
        else
          state_d = S_EX;
`else
        state_d = S_EX;
`endif
      end
      S_EX:    state_d = S_WB;
      S_WB:    state_d = S_IDLE;
      S_ILL:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Moore output decode from state and IR; reset suppresses writes, latch loads and completion.
  always_comb begin
    BUSY   = (state_q != S_IDLE);
    DONE   = 1'b0;
    ERR    = 1'b0;
    WRA    = 3'd0;
    RDA0   = 3'd0;
    RDA1   = 3'd0;
    ENW    = 1'b0;
    ENR0   = 1'b0;
    Ain    = 1'b0;
    Gin    = 1'b0;
    ALUcmd = 3'b000;
    DSel   = DSEL_EXTD;
    EXTD   = extd_q;
    case (state_q)
      S_LDWR: begin
        ENW  = 1'b1;
        WRA  = rx;
        DSel = DSEL_EXTD;
        DONE = 1'b1;
      end
      S_RD: begin
`ifdef CTRL_COPY_BYPASS_EN
        if (op == OP_COPY) begin
          ENW  = 1'b1;
          WRA  = rx;
          RDA1 = ry;
          DSel = DSEL_Q1;
          DONE = 1'b1;
        end else begin
          ENR0 = 1'b1;
          RDA0 = rx;
          RDA1 = ry;
          Ain  = 1'b1;
        end
`else
        ENR0 = 1'b1;
        RDA0 = rx;
        RDA1 = ry;
        Ain  = 1'b1;
`endif
      end
      S_EX: begin
        RDA1   = ry;
        ALUcmd = alu_sel;
        Gin    = 1'b1;
      end
      S_WB: begin
        ENW  = 1'b1;
        WRA  = rx;
        DSel = DSEL_G;
        DONE = 1'b1;
      end
      S_ILL: begin
        DONE = 1'b1;
        ERR  = 1'b1;
      end
      default: ;
    endcase
    if (CLR) begin
      ENW  = 1'b0;
      Ain  = 1'b0;
      Gin  = 1'b0;
      DONE = 1'b0;
      ERR  = 1'b0;
    end
  end

endmodule
